// File: rtl/nd_2to1_rr_pkg.sv
// Shared widths, arbiter state encoding and toggle helper for the 2-to-1 round-robin node.
package nd_2to1_rr_pkg;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;
  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  typedef enum logic {
    NS_ARB_IDLE = 1'b0,
    NS_ARB_WAIT = 1'b1
  } arb_state_t;

  function automatic logic ns_bit_toggle(input logic b);
    return ~b;
  endfunction

endpackage

// File: rtl/nd_2to1_rr_sync2.sv
// Two-flop synchroniser for a single toggle line crossing in from a divided clock domain.
module nd_2to1_rr_sync2 (
  input  logic i_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nd_2to1_rr.sv
// Round-robin merge of two toggle-handshake channels onto one outgoing channel.
module nd_2to1_rr
  import nd_2to1_rr_pkg::*;
#(
  parameter int ASZ  = NS_ADDRESS_SIZE,
  parameter int DSZ  = NS_DATA_SIZE,
  parameter int SYNC = 1
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic [ASZ-1:0] rcv0_addr,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv1_addr,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic           rcv1_req,
  output logic           rcv1_ack,
  output logic [ASZ-1:0] snd0_addr,
  output logic [DSZ-1:0] snd0_dat,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic           last_grant
);

  logic sreq0, sreq1, sack;

  generate
    if (SYNC != 0) begin : g_sync
      nd_2to1_rr_sync2 u_sync_req0 (.i_clk(i_clk), .reset(reset), .d(rcv0_req), .q(sreq0));
      nd_2to1_rr_sync2 u_sync_req1 (.i_clk(i_clk), .reset(reset), .d(rcv1_req), .q(sreq1));
      nd_2to1_rr_sync2 u_sync_ack  (.i_clk(i_clk), .reset(reset), .d(snd0_ack), .q(sack));
    end else begin : g_raw
      assign sreq0 = rcv0_req;
      assign sreq1 = rcv1_req;
      assign sack  = snd0_ack;
    end
  endgenerate

  arb_state_t     state, state_nxt;
  logic           pend0, pend1, grant;
  logic [ASZ-1:0] addr_nxt;
  logic [DSZ-1:0] dat_nxt;
  logic           req_nxt, ack0_nxt, ack1_nxt, last_nxt;

  assign pend0 = (sreq0 != rcv0_ack);
  assign pend1 = (sreq1 != rcv1_ack);

  // On a tie the input not served last wins, so two busy producers alternate.
  always_comb begin
    state_nxt = state;
    addr_nxt  = snd0_addr;
    dat_nxt   = snd0_dat;
    req_nxt   = snd0_req;
    ack0_nxt  = rcv0_ack;
    ack1_nxt  = rcv1_ack;
    last_nxt  = last_grant;
    grant     = 1'b0;
    case (state)
      NS_ARB_IDLE: begin
        if (pend0 || pend1) begin
          grant = (pend0 && pend1) ? ~last_grant : pend1;
          if (grant) begin
            addr_nxt = rcv1_addr;
            dat_nxt  = rcv1_dat;
            ack1_nxt = sreq1;
          end else begin
            addr_nxt = rcv0_addr;
            dat_nxt  = rcv0_dat;
            ack0_nxt = sreq0;
          end
          req_nxt   = ns_bit_toggle(snd0_req);
          last_nxt  = grant;
          state_nxt = NS_ARB_WAIT;
        end
      end
      NS_ARB_WAIT: begin
        if (sack == snd0_req) state_nxt = NS_ARB_IDLE;
      end
      default: state_nxt = NS_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state      <= NS_ARB_IDLE;
      ready      <= NS_OFF;
      snd0_addr  <= '0;
      snd0_dat   <= '0;
      snd0_req   <= 1'b0;
      rcv0_ack   <= 1'b0;
      rcv1_ack   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      ready      <= NS_ON;
      snd0_addr  <= addr_nxt;
      snd0_dat   <= dat_nxt;
      snd0_req   <= req_nxt;
      rcv0_ack   <= ack0_nxt;
      rcv1_ack   <= ack1_nxt;
      last_grant <= last_nxt;
    end
  end

endmodule

// File: tb/tb_nd_2to1_rr.sv
// Directed and randomised checks of the 2-to-1 round-robin node against a queue-based reference model.
module tb_nd_2to1_rr;

  localparam int ASZ = 8;
  localparam int DSZ = 8;

  logic           i_clk = 1'b0;
  logic           reset;
  logic           ready;
  logic [ASZ-1:0] rcv_addr [2];
  logic [DSZ-1:0] rcv_dat  [2];
  logic           rcv_req  [2];
  logic           rcv0_ack, rcv1_ack;
  logic [ASZ-1:0] snd0_addr;
  logic [DSZ-1:0] snd0_dat;
  logic           snd0_req;
  logic           snd0_ack;
  logic           last_grant;

  int checks = 0;
  int errors = 0;

  nd_2to1_rr #(.ASZ(ASZ), .DSZ(DSZ), .SYNC(1)) dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv0_addr(rcv_addr[0]), .rcv0_dat(rcv_dat[0]), .rcv0_req(rcv_req[0]), .rcv0_ack(rcv0_ack),
    .rcv1_addr(rcv_addr[1]), .rcv1_dat(rcv_dat[1]), .rcv1_req(rcv_req[1]), .rcv1_ack(rcv1_ack),
    .snd0_addr(snd0_addr), .snd0_dat(snd0_dat), .snd0_req(snd0_req), .snd0_ack(snd0_ack),
    .last_grant(last_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ackOf(input int s);
    return (s == 0) ? rcv0_ack : rcv1_ack;
  endfunction

  // Producer s presents a new message and flips its request line.
  task automatic applyStimulus(input int s, input logic [ASZ-1:0] a, input logic [DSZ-1:0] d);
    rcv_addr[s] = a;
    rcv_dat[s]  = d;
    rcv_req[s]  = ~rcv_req[s];
  endtask

  task automatic clearBench();
    for (int s = 0; s < 2; s++) begin
      rcv_addr[s] = '0;
      rcv_dat[s]  = '0;
      rcv_req[s]  = 1'b0;
    end
    snd0_ack = 1'b0;
  endtask

  task automatic doReset(input int cycles);
    @(negedge i_clk);
    reset = 1'b1;
    clearBench();
    repeat (cycles) @(negedge i_clk);
    reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic waitSnd(input int budget, output bit seen);
    logic prev;
    prev = snd0_req;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge i_clk);
      if (snd0_req !== prev) seen = 1'b1;
    end
  endtask

  // Producers send n0/n1 tagged messages (addr MSB = source, low bits = sequence);
  // the sink acks each output; every output is matched against per-source FIFOs.
  task automatic runTraffic(input int n0, input int n1, input int srcDiv, input int sinkDiv,
                            input bit strictAlt);
    logic [ASZ+DSZ-1:0] sb [2][$];
    int   nWant [2];
    int   sent  [2];
    int   rx, sinkWait, qs;
    bit   sinkPend, done;
    logic lastReq, expSrc, src;
    logic [ASZ-1:0] a;
    logic [DSZ-1:0] d;
    logic [ASZ+DSZ-1:0] exp;
    nWant[0] = n0; nWant[1] = n1;
    sent[0] = 0; sent[1] = 0;
    rx = 0; sinkWait = 0; sinkPend = 1'b0; done = 1'b0;
    lastReq = snd0_req;
    expSrc = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge i_clk);
      if (snd0_req !== lastReq) begin
        lastReq = snd0_req;
        src = snd0_addr[ASZ-1];
        rx++;
        qs = sb[src].size();
        checkOutput("sb_expected", qs > 0, 1);
        if (qs > 0) begin
          exp = sb[src].pop_front();
          checkOutput("sb_msg", {snd0_addr, snd0_dat}, exp);
        end
        checkOutput("sb_last_grant", last_grant, src);
        if (strictAlt) begin
          checkOutput("rr_order", src, expSrc);
          expSrc = ~src;
        end
        sinkPend = 1'b1;
        sinkWait = $urandom_range(0, 3);
      end
      if (sinkPend) begin
        if (sinkWait > 0) sinkWait--;
        else if (cyc % sinkDiv == 0) begin
          snd0_ack = snd0_req;
          sinkPend = 1'b0;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (sent[s] < nWant[s] && cyc % srcDiv == 0 && ackOf(s) == rcv_req[s]) begin
          a = ASZ'(sent[s]);
          a[ASZ-1] = s[0];
          d = DSZ'($urandom_range(0, 15));
          sb[s].push_back({a, d});
          applyStimulus(s, a, d);
          sent[s]++;
        end
      end
      done = (sent[0] == n0) && (sent[1] == n1) && (sb[0].size() == 0) && (sb[1].size() == 0)
             && !sinkPend && (rcv0_ack == rcv_req[0]) && (rcv1_ack == rcv_req[1]);
    end
    checkOutput("traffic_done", done, 1);
    checkOutput("rx_count", rx, n0 + n1);
  endtask

  initial begin
    bit seen;
    int changes;
    reset = 1'b1;
    clearBench();

    // Reset held for five cycles, then released
    repeat (5) @(negedge i_clk);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_snd_req", snd0_req, 0);
    checkOutput("rst_snd_addr", snd0_addr, 0);
    checkOutput("rst_snd_dat", snd0_dat, 0);
    checkOutput("rst_ack0", rcv0_ack, 0);
    checkOutput("rst_ack1", rcv1_ack, 0);
    checkOutput("rst_last_grant", last_grant, 1);
    reset = 1'b0;
    #1 checkOutput("ready_before_edge", ready, 0);
    @(negedge i_clk);
    checkOutput("ready_after_edge", ready, 1);

    // Single message on input 0: three-edge latency through the synchronisers
    applyStimulus(0, 8'd2, 8'd7);
    repeat (2) @(negedge i_clk);
    checkOutput("single_not_early", snd0_req, 0);
    @(negedge i_clk);
    checkOutput("single_req", snd0_req, 1);
    checkOutput("single_dat", snd0_dat, 7);
    checkOutput("single_addr", snd0_addr, 2);
    checkOutput("single_ack0", rcv0_ack, rcv_req[0]);
    checkOutput("single_last", last_grant, 0);

    // Input 1 becomes pending while the output is unacknowledged: it must be held
    applyStimulus(1, 8'd3, 8'd8);
    changes = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (snd0_req !== 1'b1 || rcv1_ack !== 1'b0) changes++;
    end
    checkOutput("wait_no_regrant", changes, 0);
    snd0_ack = snd0_req;
    waitSnd(12, seen);
    checkOutput("held_served", seen, 1);
    checkOutput("held_dat", snd0_dat, 8);
    checkOutput("held_addr", snd0_addr, 3);
    checkOutput("held_ack1", rcv1_ack, rcv_req[1]);
    checkOutput("held_last", last_grant, 1);
    snd0_ack = snd0_req;

    // Tie right after reset: input 0 first, then input 1
    doReset(3);
    applyStimulus(0, 8'd1, 8'd4);
    applyStimulus(1, 8'd5, 8'd9);
    waitSnd(6, seen);
    checkOutput("tie_first_seen", seen, 1);
    checkOutput("tie_first_dat", snd0_dat, 4);
    checkOutput("tie_first_last", last_grant, 0);
    snd0_ack = snd0_req;
    waitSnd(12, seen);
    checkOutput("tie_second_seen", seen, 1);
    checkOutput("tie_second_dat", snd0_dat, 9);
    checkOutput("tie_second_last", last_grant, 1);
    snd0_ack = snd0_req;

    // Saturation: both producers resend immediately, strict alternation expected
    doReset(2);
    runTraffic(10, 10, 1, 1, 1'b1);

    // Producers on a /8 cadence, sink on a /16 cadence, random data
    doReset(2);
    runTraffic(12, 12, 8, 16, 1'b0);

    // Reset while waiting for the downstream acknowledge
    doReset(2);
    applyStimulus(1, 8'd4, 8'd5);
    waitSnd(6, seen);
    checkOutput("midwait_granted", seen, 1);
    checkOutput("midwait_ack1", rcv1_ack, 1);
    checkOutput("midwait_dat", snd0_dat, 5);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_snd_req", snd0_req, 0);
    checkOutput("midrst_ack0", rcv0_ack, 0);
    checkOutput("midrst_ack1", rcv1_ack, 0);
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_dat", snd0_dat, 0);
    checkOutput("midrst_last", last_grant, 1);
    clearBench();
    @(negedge i_clk);
    reset = 1'b0;
    waitSnd(10, seen);
    checkOutput("midrst_quiet", seen, 0);
    applyStimulus(0, 8'd1, 8'd6);
    waitSnd(6, seen);
    checkOutput("midrst_idle_grant", seen, 1);
    checkOutput("midrst_idle_dat", snd0_dat, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
